ucore_dispatcher: RTL and testbench
===================================

UCORE_DISPATCHER -- requirements
Module: ucore_dispatcher

Interface
REQ-001 SHALL provide parameter TIMEOUT_CYCLES, default 255, meaning max WAIT cycles before abort (1..65535).
REQ-002 SHALL provide parameter W, default 18, meaning per-axis word width; vectors are 3*W packed {Z,Y,X}.
REQ-003 SHALL have port clk  in  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-low reset.
REQ-005 SHALL have ports req_valid in 1 / req_ready out 1  job request handshake.
REQ-006 SHALL have ports req_ptr in 5 and req_a, req_b, req_c in 3*W each  job microcode start pointer and A/B/C operand vectors.
REQ-007 SHALL have ports uc_run out 1, uc_start_ptr out 5, uc_a, uc_b, uc_c out 3*W  drive to engine core.
REQ-008 SHALL have ports uc_ready in 1, uc_done in 1, uc_result in 3*W  engine status and result vector.
REQ-009 SHALL have ports res_valid out 1 / res_ready in 1, res_data out 3*W, res_timeout out 1  result handshake.
REQ-010 SHALL have port jobs_done out 16  wrapping count of completed responses.

Function
REQ-011 SHALL implement states IDLE, ISSUE, WAIT, RESP.
REQ-012 SHALL assert req_ready only in IDLE; a job is accepted on req_valid&&req_ready, latched in that cycle, and the FSM enters ISSUE.
REQ-013 SHALL hold uc_start_ptr/uc_a/uc_b/uc_c at the latched job values from acceptance until leaving WAIT.
REQ-014 SHALL in ISSUE stall while uc_ready=0, and assert uc_run for exactly one cycle once uc_ready=1, then enter WAIT.
REQ-015 SHALL ignore uc_done during the uc_run cycle; uc_done is sampled from the following cycle.
REQ-016 SHALL in WAIT on uc_done=1 register uc_result into res_data and enter RESP; res_valid rises on the next cycle (latency done->res_valid = 1 cycle).
REQ-017 SHALL hold res_valid, res_data, res_timeout stable in RESP until res_ready=1, then return to IDLE, increment jobs_done (mod 2^16), and assert req_ready on the next cycle.
REQ-018 SHALL keep uc_run=0 in every state other than the single ISSUE fire cycle.
REQ-019 SHALL not support back-to-back acceptance: minimum request-to-request spacing = 4 cycles.

Reset
REQ-020 SHALL on rst=0 force IDLE and set req_ready=1, uc_run=0, uc_start_ptr=0, uc_a/b/c=0, res_valid=0, res_data=0, res_timeout=0, jobs_done=0, timeout counter=0.
REQ-021 SHALL on reset mid-job discard the job without a response and without a jobs_done increment.

Configuration
REQ-022 SHALL with UCORE_DISPATCH_TIMEOUT_EN defined count WAIT cycles; on reaching TIMEOUT_CYCLES without uc_done, enter RESP with res_data=0 and res_timeout=1; simultaneous done and expiry resolves as done with res_timeout=0.
REQ-023 SHALL without UCORE_DISPATCH_TIMEOUT_EN wait indefinitely in WAIT, omit the counter, and tie res_timeout to 0.

Structure
REQ-024 SHALL place the state enum, W default, and vector-slice index constants (X/Y/Z offsets) in shared package ucore_pkg.
REQ-025 SHALL be a single module; the timeout counter is inline, with no sub-module.

Verification
REQ-026 Reset mid-WAIT: job ptr=5'b10000 issued, rst=0 for 1 cycle -> req_ready=1, res_valid=0, jobs_done=0, uc_run=0.
REQ-027 Nominal: req_ptr=5'b01111, req_a={3{18'h20001}}, uc_ready=1, uc_done 3 cycles after run, uc_result=54'h1 -> single uc_run pulse with ptr 01111; res_data=54'h1 one cycle after done; jobs_done=1.
REQ-028 Engine busy: uc_ready=0 for 6 cycles after accept -> uc_run held low, then exactly one pulse on first uc_ready=1 cycle.
REQ-029 Backpressure: res_ready=0 for 10 cycles -> res_valid/res_data stable, req_ready=0 throughout, a second req_valid not accepted.
REQ-030 Timeout (macro on, TIMEOUT_CYCLES=8): uc_done never asserted -> res_valid with res_timeout=1, res_data=0 after 8 WAIT cycles; a second run with uc_done on cycle 8 -> res_timeout=0.
REQ-031 Wrap: preload 65535 completions (forced) plus one job -> jobs_done=0.

Source files
------------

// File: rtl/ucore_pkg.sv
// Shared types and constants for the micro-engine job dispatcher.
package ucore_pkg;
    localparam int UCORE_W = 18;
    localparam int AXIS_X  = 0;
    localparam int AXIS_Y  = AXIS_X + 1;
    localparam int AXIS_Z  = AXIS_Y + 1;
    localparam int N_AXES  = AXIS_Z + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } ucore_state_e;
endpackage

// File: rtl/ucore_dispatcher.sv
// Hands one job at a time to the engine core, returns its result; UCORE_DISPATCH_TIMEOUT_EN adds a WAIT abort.
// Latency: accept->ISSUE 1 cycle, uc_done->res_valid 1 cycle.
// Backpressure: req_ready only in IDLE; RESP holds res_* stable until res_ready.
module ucore_dispatcher
    import ucore_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int W              = UCORE_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [4:0]            req_ptr,
    input  logic [N_AXES*W-1:0]   req_a,
    input  logic [N_AXES*W-1:0]   req_b,
    input  logic [N_AXES*W-1:0]   req_c,
    output logic                  uc_run,
    output logic [4:0]            uc_start_ptr,
    output logic [N_AXES*W-1:0]   uc_a,
    output logic [N_AXES*W-1:0]   uc_b,
    output logic [N_AXES*W-1:0]   uc_c,
    input  logic                  uc_ready,
    input  logic                  uc_done,
    input  logic [N_AXES*W-1:0]   uc_result,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [N_AXES*W-1:0]   res_data,
    output logic                  res_timeout,
    output logic [15:0]           jobs_done
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("ucore_dispatcher: TIMEOUT_CYCLES must be within 1..65535");
    end

    ucore_state_e state, state_nxt;
    logic accept, done_hit, expire, resp_taken, tmo_hit;

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        uc_run     = 1'b0;
        res_valid  = 1'b0;
        accept     = 1'b0;
        done_hit   = 1'b0;
        expire     = 1'b0;
        resp_taken = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (uc_ready) begin
                    uc_run    = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                // done wins over a simultaneous expiry
                if (uc_done) begin
                    done_hit  = 1'b1;
                    state_nxt = RESP;
                end else if (tmo_hit) begin
                    expire    = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    resp_taken = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            uc_start_ptr <= '0;
            uc_a         <= '0;
            uc_b         <= '0;
            uc_c         <= '0;
            res_data     <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                uc_start_ptr <= req_ptr;
                uc_a         <= req_a;
                uc_b         <= req_b;
                uc_c         <= req_c;
            end
            if (done_hit) begin
                for (int ax = AXIS_X; ax <= AXIS_Z; ax++)
                    res_data[ax*W +: W] <= uc_result[ax*W +: W];
            end else if (expire) begin
                res_data <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)
            jobs_done <= '0;
        else if (resp_taken)
            jobs_done <= jobs_done + 16'd1;
    end

`ifdef UCORE_DISPATCH_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] tmo_cnt;

    // counts completed WAIT cycles; cleared whenever not waiting
    always_ff @(posedge clk) begin
        if (!rst)
            tmo_cnt <= '0;
        else if (state == WAIT && !uc_done)
            tmo_cnt <= tmo_cnt + 16'd1;
        else
            tmo_cnt <= '0;
    end

    assign tmo_hit = (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (!rst)
            res_timeout <= 1'b0;
        else if (done_hit)
            res_timeout <= 1'b0;
        else if (expire)
            res_timeout <= 1'b1;
    end
`else
    assign tmo_hit     = 1'b0;
    assign res_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ucore_dispatcher.sv
// Directed bench for ucore_dispatcher: a phase-level job model checked every cycle,
// plus hand-computed expectations per scenario.
module tb_ucore_dispatcher;
    localparam int W    = 18;
    localparam int VW   = 3 * W;
    localparam int TMO  = 8;
`ifdef UCORE_DISPATCH_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    typedef logic [VW-1:0] vec_t;

    logic        clk;
    logic        rst;
    logic        req_valid, req_ready;
    logic [4:0]  req_ptr;
    vec_t        req_a, req_b, req_c;
    logic        uc_run;
    logic [4:0]  uc_start_ptr;
    vec_t        uc_a, uc_b, uc_c;
    logic        uc_ready, uc_done;
    vec_t        uc_result;
    logic        res_valid, res_ready, res_timeout;
    vec_t        res_data;
    logic [15:0] jobs_done;

    ucore_dispatcher #(.TIMEOUT_CYCLES(TMO), .W(W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_ptr(req_ptr), .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .uc_run(uc_run), .uc_start_ptr(uc_start_ptr),
        .uc_a(uc_a), .uc_b(uc_b), .uc_c(uc_c),
        .uc_ready(uc_ready), .uc_done(uc_done), .uc_result(uc_result),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_timeout(res_timeout),
        .jobs_done(jobs_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int runs  = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Job-level model: one outstanding job moving through accept / run / wait / respond.
    logic        m_busy, m_ran, m_waiting, m_has_resp, m_resp_to;
    int          m_wait;
    logic [4:0]  m_ptr;
    vec_t        m_a, m_b, m_c, m_resp;
    logic [15:0] m_jobs;

    always @(negedge clk) begin
        if (!rst) begin
            m_busy = 0; m_ran = 0; m_waiting = 0; m_has_resp = 0; m_resp_to = 0;
            m_wait = 0; m_jobs = 16'd0;
        end else begin
            check("m_req_ready", 64'(req_ready), 64'(!m_busy));
            check("m_uc_run", 64'(uc_run), 64'(m_busy && !m_ran && uc_ready));
            if (uc_run) begin
                runs++;
                check("m_run_ptr", 64'(uc_start_ptr), 64'(m_ptr));
                check("m_run_a", 64'(uc_a), 64'(m_a));
                check("m_run_b", 64'(uc_b), 64'(m_b));
                check("m_run_c", 64'(uc_c), 64'(m_c));
            end
            check("m_res_valid", 64'(res_valid), 64'(m_has_resp));
            if (m_has_resp) begin
                check("m_res_data", 64'(res_data), 64'(m_resp));
                check("m_res_timeout", 64'(res_timeout), 64'(m_resp_to));
            end
            check("m_jobs_done", 64'(jobs_done), 64'(m_jobs));

            if (!m_busy) begin
                if (req_valid) begin
                    m_busy = 1; m_ran = 0; m_waiting = 0;
                    m_ptr = req_ptr; m_a = req_a; m_b = req_b; m_c = req_c;
                end
            end else if (!m_ran) begin
                if (uc_ready) begin
                    m_ran = 1; m_waiting = 1; m_wait = 0;
                end
            end else if (m_waiting) begin
                m_wait++;
                if (uc_done) begin
                    m_waiting = 0; m_has_resp = 1; m_resp = uc_result; m_resp_to = 0;
                end else if (TMO_EN && m_wait == TMO) begin
                    m_waiting = 0; m_has_resp = 1; m_resp = '0; m_resp_to = 1;
                end
            end else if (res_ready) begin
                m_busy = 0; m_has_resp = 0; m_jobs = m_jobs + 16'd1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // done_at: WAIT cycle (1-based) on which uc_done is raised; 0 means never.
    task automatic do_job(input logic [4:0] p, input vec_t a, input vec_t b, input vec_t c,
                          input int busy, input int done_at, input int hold,
                          input vec_t result, input bit exp_to, input bit early_done);
        int lat;
        req_valid = 1; req_ptr = p; req_a = a; req_b = b; req_c = c;
        uc_ready = (busy == 0);
        tick();
        req_valid = 0;
        for (int i = 0; i < busy; i++) begin
            check("busy_no_run", 64'(uc_run), 64'd0);
            tick();
        end
        uc_ready = 1;
        uc_done = early_done;
        uc_result = ~result;
        #1;
        check("run_pulse", 64'(uc_run), 64'd1);
        check("run_ptr", 64'(uc_start_ptr), 64'(p));
        check("run_a", 64'(uc_a), 64'(a));
        tick();
        uc_done = 0;
        check("run_single", 64'(uc_run), 64'd0);
        if (done_at == 0) begin
            lat = 0;
            for (int n = 1; n <= 40 && lat == 0; n++) begin
                tick();
                if (res_valid) lat = n;
            end
            check("tmo_latency", 64'(lat), 64'(TMO));
        end else begin
            for (int i = 1; i < done_at; i++) begin
                check("wait_no_resp", 64'(res_valid), 64'd0);
                tick();
            end
            uc_done = 1; uc_result = result;
            tick();
            uc_done = 0; uc_result = ~result;
        end
        check("resp_valid", 64'(res_valid), 64'd1);
        check("resp_data", 64'(res_data), 64'(result));
        check("resp_timeout", 64'(res_timeout), 64'(exp_to));
        res_ready = 0;
        for (int i = 0; i < hold; i++) begin
            req_valid = 1; req_ptr = ~p; req_a = ~a;
            tick();
            check("hold_req_ready", 64'(req_ready), 64'd0);
            check("hold_res_valid", 64'(res_valid), 64'd1);
            check("hold_res_data", 64'(res_data), 64'(result));
        end
        req_valid = 0;
        res_ready = 1;
        tick();
        res_ready = 0;
        check("post_res_valid", 64'(res_valid), 64'd0);
        check("post_req_ready", 64'(req_ready), 64'd1);
    endtask

    initial begin
        int r0;
        rst = 0; req_valid = 0; req_ptr = '0; req_a = '0; req_b = '0; req_c = '0;
        uc_ready = 0; uc_done = 0; uc_result = '0; res_ready = 0;
        tick(); tick();
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_uc_run", 64'(uc_run), 64'd0);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_jobs_done", 64'(jobs_done), 64'd0);
        check("rst_res_data", 64'(res_data), 64'd0);
        check("rst_uc_ptr", 64'(uc_start_ptr), 64'd0);
        check("rst_uc_a", 64'(uc_a), 64'd0);
        check("rst_res_timeout", 64'(res_timeout), 64'd0);
        rst = 1;
        tick();

        // nominal job, done three cycles after the run pulse
        do_job(5'b01111, {3{18'h20001}}, 54'h0, 54'h3FFFFFFFFFFFFF, 0, 3, 0, 54'h1, 0, 0);
        check("nom_jobs_done", 64'(jobs_done), 64'd1);
        check("nom_runs", 64'(runs), 64'd1);

        // engine busy for six cycles; uc_done held during the run cycle is ignored
        do_job(5'b00101, 54'h15555555555555, 54'h2AAAAAAAAAAAAA, 54'h00000012345678,
               6, 1, 0, 54'h2ABCDE12345678, 0, 1);
        check("busy_jobs_done", 64'(jobs_done), 64'd2);
        check("busy_runs", 64'(runs), 64'd2);

        // result backpressure for ten cycles with a competing request
        do_job(5'b11010, 54'h0000000003FFFF, 54'h3FFFF000000000, 54'h1, 0, 2, 10,
               54'h123456789ABCDE, 0, 0);
        check("bp_jobs_done", 64'(jobs_done), 64'd3);
        check("bp_runs", 64'(runs), 64'd3);

        // reset in the middle of WAIT drops the job
        r0 = runs;
        req_valid = 1; req_ptr = 5'b10000; req_a = 54'h7; uc_ready = 1;
        tick();
        req_valid = 0;
        tick(); tick();
        rst = 0;
        tick();
        rst = 1;
        check("mid_rst_req_ready", 64'(req_ready), 64'd1);
        check("mid_rst_res_valid", 64'(res_valid), 64'd0);
        check("mid_rst_jobs_done", 64'(jobs_done), 64'd0);
        check("mid_rst_uc_run", 64'(uc_run), 64'd0);
        uc_done = 1; uc_result = 54'h55;
        tick(); tick(); tick();
        uc_done = 0;
        check("mid_rst_no_resp", 64'(res_valid), 64'd0);
        check("mid_rst_runs", 64'(runs - r0), 64'd1);

        // jobs at minimum spacing
        do_job(5'b00001, 54'h1, 54'h2, 54'h3, 0, 1, 0, 54'h3FFFF00000001, 0, 0);
        do_job(5'b11111, 54'h3FFFFFFFFFFFFF, 54'h0, 54'h0, 0, 1, 0, 54'h0, 0, 0);
        check("spacing_jobs_done", 64'(jobs_done), 64'd2);

        // jobs_done wrap
        force dut.jobs_done = 16'hFFFF;
        m_jobs = 16'hFFFF;
        tick();
        release dut.jobs_done;
        tick();
        check("wrap_preload", 64'(jobs_done), 64'hFFFF);
        do_job(5'b01010, 54'h9, 54'h8, 54'h7, 0, 4, 1, 54'h2468, 0, 0);
        check("wrap_jobs_done", 64'(jobs_done), 64'd0);

`ifdef UCORE_DISPATCH_TIMEOUT_EN
        do_job(5'b00110, 54'h11, 54'h22, 54'h33, 0, 0, 2, 54'h0, 1, 0);
        check("tmo_jobs_done", 64'(jobs_done), 64'd1);
        do_job(5'b00111, 54'h44, 54'h55, 54'h66, 0, TMO, 0, 54'h1ABCD, 0, 0);
        check("tmo_race_jobs_done", 64'(jobs_done), 64'd2);
`endif

        tick(); tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end

endmodule
